// File: rtl/sockit_spi_pkg.sv
// sockit_spi_pkg
// Shared types for the sockit SPI blocks.
//   slv_state_t : SPI slave transfer state (IDLE between frames, SHIFT while
//                 slave select is asserted).
//   SYN_STAGES  : depth of the pin synchronizers in the slave.
package sockit_spi_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } slv_state_t;

    localparam int SYN_STAGES = 2;

endpackage

// File: rtl/sockit_spi_syn.sv
// sockit_spi_syn
// N-stage flip-flop synchronizer for a single asynchronous input.
//   clk : destination clock
//   rst : asynchronous reset, active-low; all stages load RST_VAL
//   d   : asynchronous input
//   q   : synchronized output (STAGES clk cycles of latency)
module sockit_spi_syn #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync <= {STAGES{RST_VAL}};
        end else begin
            sync <= {sync[STAGES-2:0], d};
        end
    end

    assign q = sync[STAGES-1];

endmodule

// File: rtl/sockit_spi_slv.sv
// sockit_spi_slv
// Oversampled single-wire SPI slave, MSB first, mode fixed by CPOL/CPHA.
//   clk, rst                : system clock, asynchronous active-low reset
//   spi_sclk/ss_n/mosi      : SPI pins from the master (asynchronous)
//   spi_miso, spi_miso_oe   : slave data out and its pad enable
//   txd_*                   : transmit word stream (txd_tready is a pulse)
//   rxd_*                   : received word stream
//   sts_act                 : slave select seen asserted (transfer active)
//   sts_udf/ovf/abt         : underflow / overflow / abort pulses
module sockit_spi_slv
    import sockit_spi_pkg::*;
#(
    parameter int             SDW  = 8,
    parameter logic           CPOL = 1'b0,
    parameter logic           CPHA = 1'b0,
    parameter logic [SDW-1:0] UDF  = {SDW{1'b1}}
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           spi_sclk,
    input  logic           spi_ss_n,
    input  logic           spi_mosi,
    output logic           spi_miso,
    output logic           spi_miso_oe,
    input  logic [SDW-1:0] txd_tdata,
    input  logic           txd_tvalid,
    output logic           txd_tready,
    output logic [SDW-1:0] rxd_tdata,
    output logic           rxd_tvalid,
    input  logic           rxd_tready,
    output logic           sts_act,
    output logic           sts_udf,
    output logic           sts_ovf,
    output logic           sts_abt
);

    localparam int           CW   = (SDW > 2) ? $clog2(SDW) : 1;
    localparam logic [CW-1:0] LAST = CW'(SDW - 1);

    logic sclk_s, ss_n_s, mosi_s;

    sockit_spi_syn #(.STAGES(SYN_STAGES), .RST_VAL(CPOL)) u_syn_sclk (
        .clk(clk), .rst(rst), .d(spi_sclk), .q(sclk_s));
    sockit_spi_syn #(.STAGES(SYN_STAGES), .RST_VAL(1'b1)) u_syn_ss_n (
        .clk(clk), .rst(rst), .d(spi_ss_n), .q(ss_n_s));
    sockit_spi_syn #(.STAGES(SYN_STAGES), .RST_VAL(1'b0)) u_syn_mosi (
        .clk(clk), .rst(rst), .d(spi_mosi), .q(mosi_s));

    // Edge-detect stage: registered pulses, with mosi delayed to stay aligned.
    logic sclk_d, ss_n_d;
    logic lead_p1, trail_p1, ss_fall_p1, ss_rise_p1, mosi_p1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sclk_d     <= CPOL;
            ss_n_d     <= 1'b1;
            lead_p1    <= 1'b0;
            trail_p1   <= 1'b0;
            ss_fall_p1 <= 1'b0;
            ss_rise_p1 <= 1'b0;
            mosi_p1    <= 1'b0;
        end else begin
            sclk_d     <= sclk_s;
            ss_n_d     <= ss_n_s;
            lead_p1    <= (sclk_d == CPOL) && (sclk_s != CPOL);
            trail_p1   <= (sclk_d != CPOL) && (sclk_s == CPOL);
            ss_fall_p1 <= ss_n_d && !ss_n_s;
            ss_rise_p1 <= !ss_n_d && ss_n_s;
            mosi_p1    <= mosi_s;
        end
    end

    // Action stage.
    slv_state_t     state;
    logic [CW-1:0]  cnt;
    logic [SDW-1:0] rx_sr, tx_sr, ld_word;
    logic           smp_p1, shf_p1, smp_en, do_load, do_shift, word_done;

    assign smp_p1 = CPHA ? trail_p1 : lead_p1;
    assign shf_p1 = CPHA ? lead_p1  : trail_p1;

    // SS rising has priority over any clock edge detected in the same cycle.
    assign smp_en    = (state == SHIFT) && !ss_rise_p1 && smp_p1;
    assign word_done = smp_en && (cnt == LAST);
    assign do_shift  = (state == SHIFT) && !ss_rise_p1 && shf_p1 && (cnt != '0);
    // CPHA=0 must present the first bit before the first edge, so it loads on entry.
    assign do_load   = ((state == IDLE) && ss_fall_p1 && !CPHA) ||
                       ((state == SHIFT) && !ss_rise_p1 && shf_p1 && (cnt == '0));
    assign ld_word   = txd_tvalid ? txd_tdata : UDF;

    // Shift registers carry data only and need no reset.
    always_ff @(posedge clk) begin
        if (smp_en) begin
            rx_sr <= {rx_sr[SDW-2:0], mosi_p1};
        end
        if (do_load) begin
            tx_sr <= ld_word;
        end else if (do_shift) begin
            tx_sr <= tx_sr << 1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            spi_miso    <= 1'b0;
            spi_miso_oe <= 1'b0;
            txd_tready  <= 1'b0;
            rxd_tdata   <= '0;
            rxd_tvalid  <= 1'b0;
            sts_udf     <= 1'b0;
            sts_ovf     <= 1'b0;
            sts_abt     <= 1'b0;
        end else begin
            txd_tready <= 1'b0;
            sts_udf    <= 1'b0;
            sts_ovf    <= 1'b0;
            sts_abt    <= 1'b0;

            // MISO is updated together with tx_sr so the pad sees the new bit
            // in the same cycle the shift register changes.
            if (do_load) begin
                spi_miso   <= ld_word[SDW-1];
                txd_tready <= txd_tvalid;
                sts_udf    <= !txd_tvalid;
            end else if (do_shift) begin
                spi_miso <= tx_sr[SDW-2];
            end

            if (word_done) begin
                rxd_tdata  <= {rx_sr[SDW-2:0], mosi_p1};
                rxd_tvalid <= 1'b1;
                sts_ovf    <= rxd_tvalid && !rxd_tready;
            end else if (rxd_tvalid && rxd_tready) begin
                rxd_tvalid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (ss_fall_p1) begin
                        state       <= SHIFT;
                        cnt         <= '0;
                        spi_miso_oe <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (ss_rise_p1) begin
                        state       <= IDLE;
                        cnt         <= '0;
                        spi_miso_oe <= 1'b0;
                        spi_miso    <= 1'b0;
                        sts_abt     <= (cnt != '0);
                    end else if (smp_p1) begin
                        cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign sts_act = (state == SHIFT);

endmodule

// File: tb/tb_sockit_spi_slv.sv
// tb_sockit_spi_slv
// Directed bench for sockit_spi_slv: one mode-0 and one mode-3 instance share
// the SPI clock/data pins and the stream inputs, each has its own slave select.
module tb_sockit_spi_slv;

    localparam int H = 8;   // SCLK half period in clk cycles

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, sclk, mosi, ss0, ss3, rxd_tready;
    logic       miso0, oe0, rdy0, rv0, act0, udf0, ovf0, abt0;
    logic       miso3, oe3, rdy3, rv3, act3, udf3, ovf3, abt3;
    logic [7:0] rxd0, rxd3, txd_tdata;
    logic       txd_tvalid;

    logic [7:0] txbuf [0:3];
    int         txn, txi;
    logic       mon_clr;
    int         rdy_cnt, udf_cnt, ovf_cnt, abt_cnt;
    logic [7:0] rxq [$];

    assign txd_tvalid = (txi < txn);
    assign txd_tdata  = txbuf[txi & 3];

    sockit_spi_slv #(.SDW(8), .CPOL(1'b0), .CPHA(1'b0), .UDF(8'hff)) u_dut0 (
        .clk(clk), .rst(rst), .spi_sclk(sclk), .spi_ss_n(ss0), .spi_mosi(mosi),
        .spi_miso(miso0), .spi_miso_oe(oe0),
        .txd_tdata(txd_tdata), .txd_tvalid(txd_tvalid), .txd_tready(rdy0),
        .rxd_tdata(rxd0), .rxd_tvalid(rv0), .rxd_tready(rxd_tready),
        .sts_act(act0), .sts_udf(udf0), .sts_ovf(ovf0), .sts_abt(abt0));

    sockit_spi_slv #(.SDW(8), .CPOL(1'b1), .CPHA(1'b1), .UDF(8'hff)) u_dut3 (
        .clk(clk), .rst(rst), .spi_sclk(sclk), .spi_ss_n(ss3), .spi_mosi(mosi),
        .spi_miso(miso3), .spi_miso_oe(oe3),
        .txd_tdata(txd_tdata), .txd_tvalid(txd_tvalid), .txd_tready(rdy3),
        .rxd_tdata(rxd3), .rxd_tvalid(rv3), .rxd_tready(rxd_tready),
        .sts_act(act3), .sts_udf(udf3), .sts_ovf(ovf3), .sts_abt(abt3));

    // Stream sink/source and pulse counters, sampled on the inactive edge.
    always @(negedge clk) begin
        if (mon_clr) begin
            txi     <= 0;
            rdy_cnt <= 0;
            udf_cnt <= 0;
            ovf_cnt <= 0;
            abt_cnt <= 0;
            rxq.delete();
        end else begin
            if ((rdy0 || rdy3) && (txi < txn)) txi <= txi + 1;
            if (rdy0 || rdy3) rdy_cnt <= rdy_cnt + 1;
            if (udf0 || udf3) udf_cnt <= udf_cnt + 1;
            if (ovf0 || ovf3) ovf_cnt <= ovf_cnt + 1;
            if (abt0 || abt3) abt_cnt <= abt_cnt + 1;
            if (rv0 && rxd_tready) rxq.push_back(rxd0);
            if (rv3 && rxd_tready) rxq.push_back(rxd3);
        end
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        mon_clr = 1'b1;
        txn     = 0;
        @(negedge clk);
        #1 mon_clr = 1'b0;
    endtask

    task automatic ss_on(input bit m3);
        sclk = m3;
        tick(H);
        if (m3) ss3 = 1'b0; else ss0 = 1'b0;
        tick(H);
    endtask

    task automatic ss_off(input bit m3);
        tick(H);
        if (m3) ss3 = 1'b1; else ss0 = 1'b1;
        tick(2 * H);
    endtask

    // Master side: drives nb bits of w MSB first, returns bits read from MISO.
    task automatic spi_bits(input bit m3, input logic [7:0] w, input int nb,
                            output logic [7:0] got);
        got = 8'h00;
        for (int i = 0; i < nb; i++) begin
            if (m3) sclk = 1'b0;
            mosi = w[7-i];
            tick(H);
            sclk = 1'b1;
            got = {got[6:0], (m3 ? miso3 : miso0)};
            tick(H);
            if (!m3) sclk = 1'b0;
        end
    endtask

    typedef struct packed {
        logic        m3;
        logic [1:0]  nw;
        logic [15:0] mo;
        logic [1:0]  ntx;
        logic [15:0] tx;
        logic [15:0] emiso;
        logic [3:0]  erdy;
        logic [3:0]  eudf;
    } vec_t;

    vec_t       vt [0:3];
    vec_t       v;
    logic [7:0] w, got;

    initial begin
        vt[0] = '{m3: 1'b0, nw: 2'd1, mo: 16'hA500, ntx: 2'd1, tx: 16'h3C00,
                  emiso: 16'h3C00, erdy: 4'd1, eudf: 4'd1};
        vt[1] = '{m3: 1'b1, nw: 2'd2, mo: 16'h1234, ntx: 2'd2, tx: 16'h5678,
                  emiso: 16'h5678, erdy: 4'd2, eudf: 4'd0};
        vt[2] = '{m3: 1'b1, nw: 2'd2, mo: 16'h0FF0, ntx: 2'd0, tx: 16'h0000,
                  emiso: 16'hFFFF, erdy: 4'd0, eudf: 4'd2};
        vt[3] = '{m3: 1'b0, nw: 2'd2, mo: 16'h817E, ntx: 2'd2, tx: 16'hC399,
                  emiso: 16'hC399, erdy: 4'd2, eudf: 4'd1};

        rst = 1'b0; sclk = 1'b0; mosi = 1'b0; ss0 = 1'b1; ss3 = 1'b1;
        rxd_tready = 1'b1; mon_clr = 1'b1; txn = 0;
        for (int i = 0; i < 4; i++) txbuf[i] = 8'h00;
        tick(5);
        check("rst_miso0", miso0, 1'b0);
        check("rst_oe0", oe0, 1'b0);
        check("rst_rvalid0", rv0, 1'b0);
        check("rst_rdata0", rxd0, 8'h00);
        check("rst_sts0", {act0, udf0, ovf0, abt0, rdy0}, 5'b0);
        check("rst_oe3_rvalid3", {oe3, rv3, act3}, 3'b0);
        rst = 1'b1;
        tick(4);

        for (int r = 0; r < 4; r++) begin
            v = vt[r];
            clear_mon();
            txbuf[0] = v.tx[15:8];
            txbuf[1] = v.tx[7:0];
            txn = int'(v.ntx);
            ss_on(v.m3);
            check($sformatf("v%0d_act_oe", r),
                  v.m3 ? {act3, oe3} : {act0, oe0}, 2'b11);
            for (int k = 0; k < int'(v.nw); k++) begin
                w = (k == 0) ? v.mo[15:8] : v.mo[7:0];
                spi_bits(v.m3, w, 8, got);
                check($sformatf("v%0d_miso%0d", r, k), got,
                      (k == 0) ? v.emiso[15:8] : v.emiso[7:0]);
            end
            ss_off(v.m3);
            check($sformatf("v%0d_nrx", r), rxq.size(), v.nw);
            for (int k = 0; k < int'(v.nw); k++) begin
                if (k < rxq.size())
                    check($sformatf("v%0d_rx%0d", r, k), rxq[k],
                          (k == 0) ? v.mo[15:8] : v.mo[7:0]);
            end
            check($sformatf("v%0d_tready", r), rdy_cnt, v.erdy);
            check($sformatf("v%0d_udf", r), udf_cnt, v.eudf);
            check($sformatf("v%0d_ovf_abt", r), {ovf_cnt[3:0], abt_cnt[3:0]}, 8'h00);
            check($sformatf("v%0d_idle_oe", r), v.m3 ? oe3 : oe0, 1'b0);
        end

        // Overflow: sink stalled across two words.
        clear_mon();
        rxd_tready = 1'b0;
        ss_on(1'b1);
        spi_bits(1'b1, 8'h01, 8, got);
        spi_bits(1'b1, 8'h02, 8, got);
        ss_off(1'b1);
        check("ovf_cnt", ovf_cnt, 1);
        check("ovf_rdata", rxd3, 8'h02);
        check("ovf_rvalid", rv3, 1'b1);
        rxd_tready = 1'b1;
        tick(2);
        check("ovf_drain_rvalid", rv3, 1'b0);
        check("ovf_drain_n", rxq.size(), 1);
        if (rxq.size() > 0) check("ovf_drain_word", rxq[0], 8'h02);

        // Abort after 5 bits, then a clean word.
        clear_mon();
        ss_on(1'b0);
        spi_bits(1'b0, 8'hF0, 5, got);
        ss_off(1'b0);
        check("abt_cnt", abt_cnt, 1);
        check("abt_nrx", rxq.size(), 0);
        clear_mon();
        ss_on(1'b0);
        spi_bits(1'b0, 8'hC3, 8, got);
        ss_off(1'b0);
        check("abt_next_nrx", rxq.size(), 1);
        if (rxq.size() > 0) check("abt_next_word", rxq[0], 8'hC3);
        check("abt_next_abt", abt_cnt, 0);

        // Reset mid-word.
        clear_mon();
        ss_on(1'b0);
        spi_bits(1'b0, 8'hFF, 3, got);
        rst = 1'b0;
        #1;
        check("mid_rst_oe_act", {oe0, act0}, 2'b00);
        check("mid_rst_miso", miso0, 1'b0);
        check("mid_rst_rdata", rxd0, 8'h00);
        check("mid_rst_rvalid", rv0, 1'b0);
        ss0 = 1'b1; sclk = 1'b0;
        tick(4);
        rst = 1'b1;
        tick(4);
        clear_mon();
        ss_on(1'b0);
        spi_bits(1'b0, 8'h5A, 8, got);
        ss_off(1'b0);
        check("post_rst_nrx", rxq.size(), 1);
        if (rxq.size() > 0) check("post_rst_word", rxq[0], 8'h5A);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/sockit_spi_slv.md
# sockit_spi_slv

SPI slave: the far-end counterpart of the sockit_spi master, used as an on-chip loopback target for master verification and as a standalone SPI target port. Samples SCLK, SS_N and MOSI in the system clock domain by oversampling, deserializes MOSI into SDW-bit words on a receive stream, and serializes words from a transmit stream onto MISO. Single-wire (standard) SPI only, MSB first, mode fixed by parameters.

## Interface
- SDW, 8, serial word width (bits per word, >= 2)
- CPOL, 1'b0, SCLK idle level
- CPHA, 1'b0, 0: sample on leading edge / shift on trailing; 1: shift on leading / sample on trailing
- UDF, 8'hff (SDW bits), word driven on MISO on transmit underflow

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- spi_sclk  in  1  SPI clock from master (asynchronous to clk)
- spi_ss_n  in  1  slave select, active-low (asynchronous)
- spi_mosi  in  1  master out (asynchronous)
- spi_miso  out  1  slave out data
- spi_miso_oe  out  1  MISO output enable (pad tristate control)
- txd_tdata  in  SDW  transmit word
- txd_tvalid  in  1  transmit word valid
- txd_tready  out  1  transmit word taken (single-cycle pulse)
- rxd_tdata  out  SDW  received word
- rxd_tvalid  out  1  received word valid
- rxd_tready  in  1  received word accepted
- sts_act  out  1  transfer active (synchronized SS asserted)
- sts_udf  out  1  transmit underflow, single-cycle pulse
- sts_ovf  out  1  receive overflow, single-cycle pulse
- sts_abt  out  1  partial word aborted by SS deassert, single-cycle pulse

## Operation
- spi_sclk, spi_ss_n, spi_mosi pass through 2-FF synchronizers (reset values: sclk=CPOL, ss_n=1, mosi=0), then one edge-detect register.
- Leading edge = sync sclk leaves CPOL; trailing = returns to CPOL. Sample edge = leading if CPHA=0 else trailing; shift edge = the other.
- FSM states IDLE, SHIFT. IDLE->SHIFT on sync ss_n falling; SHIFT->IDLE on sync ss_n rising. Edges seen in IDLE are ignored.
- Bit counter cnt, 0..SDW-1, cleared on entering SHIFT.
- Sample edge in SHIFT: rx shift register <= {rx[SDW-2:0], mosi_sync}; cnt++; at cnt==SDW-1 cnt wraps to 0 and word completes.
- Word complete: rxd_tdata <= assembled word, rxd_tvalid <= 1. If rxd_tvalid was 1 and rxd_tready 0 in that cycle: overwrite, sts_ovf pulse. If rxd_tready 1 in that cycle: no overflow, rxd_tvalid stays 1.
- rxd_tvalid clears on rxd_tvalid & rxd_tready when no word completes in the same cycle.
- TX load (cnt==0): CPHA=0 at SHIFT entry and at each shift edge with cnt==0; CPHA=1 at each shift edge with cnt==0. If txd_tvalid: tx <= txd_tdata, txd_tready pulse. Else tx <= UDF, sts_udf pulse.
- Shift edge with cnt!=0: tx <= tx << 1. spi_miso = tx[SDW-1] registered.
- CPHA=0 trailing edge after the last word before SS deassert still loads a word (consumes txd, or flags udf); intended.
- SS rising with cnt!=0: partial rx discarded, sts_abt pulse, no rxd_tvalid. cnt cleared.
- spi_miso_oe = 1 in SHIFT, else 0; spi_miso = 0 in IDLE.

## Timing
- Reset values: spi_miso 0, spi_miso_oe 0, txd_tready 0, rxd_tvalid 0, rxd_tdata 0, sts_* 0, state IDLE.
- Pin-to-detect latency: 3 clk cycles (2 sync + edge detect); action registered the cycle after detect.
- MISO: 4 clk cycles from pin shift edge to new bit on pad. Requirement: SCLK half-period >= 6 clk cycles (f_sclk <= f_clk/12); for CPHA=0, SS-fall to first SCLK edge >= 6 clk.
- rxd_tvalid rises 4 clk cycles after the SDW-th sample edge at the pin.
- Simultaneous SS rising and sample edge in the same detect cycle: SS rising wins, bit dropped.
- Reset asserted mid-transfer: immediate return to reset values; next transfer starts only after fresh SS falling.

## Structure
- sockit_spi_pkg: add enum slv_state_t {IDLE, SHIFT}.
- Sub-module sockit_spi_syn: parameterized N-FF synchronizer with reset value parameter, instantiated three times.
- RTL target ~200 lines.

## Test plan
- Mode 0 (CPOL=0, CPHA=0), txd 8'h3C preloaded, master sends 8'hA5 -> rxd_tdata 8'hA5 once; MISO bits 0,0,1,1,1,1,0,0; one txd_tready.
- Mode 3, two back-to-back words 8'h12, 8'h34 with txd 8'h56, 8'h78 -> rxd 8'h12 then 8'h34, MISO 8'h56 then 8'h78, no status pulses.
- txd_tvalid held 0 -> MISO 8'hff, sts_udf one pulse per word.
- rxd_tready held 0, two words 8'h01, 8'h02 -> sts_ovf once, rxd_tdata 8'h02, rxd_tvalid 1.
- SS deasserted after 5 bits -> sts_abt pulse, no rxd_tvalid; next full word 8'hC3 received correctly.
- rst low mid-word -> all outputs at reset values next cycle; subsequent transfer 8'h5A received correctly.
